// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_TX    = 2'd3
    } state_e;

    localparam int unsigned BYTE_W = 8;

    // Width of the start-timeout counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before the scan so no path leaves a value held, which would infer a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(last_i) + off) % N);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_byte among NUM_REQ byte producers,
// with a send-retry timeout when the transmitter never reports busy.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic                      hold,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      tx_send,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = int'(cnt_width(START_TIMEOUT));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 send_q, send_d;
    logic [BYTE_W-1:0]    data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [BYTE_W-1:0]    pick_byte;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) pick_byte = req_data[BYTE_W*i +: BYTE_W];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = '0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        unique case (state_q)
            ST_IDLE: begin
                // Never start while the transmitter still owns the line, e.g. a frame abandoned by reset.
                if (!hold && !tx_busy && pick_any) begin
                    grant_d = pick_grant;
                    gidx_d  = pick_idx;
                    data_d  = pick_byte;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_busy) begin
                    state_d = ST_TX;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TX: begin
                if (!tx_busy) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    last_d  = gidx_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The send pulse is registered from the next state so it coincides with the START cycle.
    assign send_d = (state_d == ST_START);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            send_q  <= send_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
        end
    end

    assign grant   = grant_q;
    assign ack     = ack_q;
    assign tx_send = send_q;
    assign tx_data = data_q;

endmodule
